hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 7 +
 rtl/md_stall_ctr.sv | 35 +++
 rtl/hazard_ctrl.sv | 100 ++++++++++
 tb/tb_hazard_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: forwarding-select codes and mul/div FSM state encoding shared by the hazard unit.
package hazard_pkg;
    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_M    = 2'b10;
    localparam logic [1:0] FWD_W    = 2'b01;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_e;
endpackage

// File: rtl/md_stall_ctr.sv
// md_stall_ctr: holds a multi-cycle mul/div in E for MD_LAT cycles and flags when its result is ready.
module md_stall_ctr
    import hazard_pkg::*;
#(
    parameter int MD_LAT = 4
) (
    input  logic clk,
    input  logic CpuRst,
    input  logic MdStartE,
    input  logic DCacheMiss,
    output logic mdStall,
    output logic MdDoneE
);
    localparam int CW = $clog2(MD_LAT);
    md_state_e state;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
        if (CpuRst) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (state == IDLE) begin
            if (MdStartE) begin
                state <= BUSY;
                cnt   <= CW'(MD_LAT - 2);
            end
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end else if (!DCacheMiss) begin
            state <= IDLE;
        end
    end
    // The result stays valid while a data-cache miss freezes the pipeline.
    assign mdStall = !CpuRst && (state == IDLE ? MdStartE : cnt != '0);
    assign MdDoneE = !CpuRst && state == BUSY && cnt == '0;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush priority, operand forwarding and mul/div stall control.
// Define HAZARD_PERF_CNT_EN to build the StallCycles counter; otherwise StallCycles is tied to 0.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W  = 5,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             CpuRst,
    input  logic             ICacheMiss,
    input  logic             DCacheMiss,
    input  logic             BranchE,
    input  logic             JalrE,
    input  logic             JalD,
    input  logic             MdStartE,
    input  logic [REG_W-1:0] Rs1D,
    input  logic [REG_W-1:0] Rs2D,
    input  logic [REG_W-1:0] Rs1E,
    input  logic [REG_W-1:0] Rs2E,
    input  logic [REG_W-1:0] RdE,
    input  logic [REG_W-1:0] RdM,
    input  logic [REG_W-1:0] RdW,
    input  logic [1:0]       RegReadE,
    input  logic             MemToRegE,
    input  logic [2:0]       RegWriteM,
    input  logic [2:0]       RegWriteW,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             StallW,
    output logic             FlushF,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             FlushW,
    output logic [1:0]       Forward1E,
    output logic [1:0]       Forward2E,
    output logic             MdDoneE,
    output logic [CNT_W-1:0] StallCycles
);
    logic md_stall;
    logic load_use;

    md_stall_ctr #(.MD_LAT(MD_LAT)) u_md (
        .clk        (clk),
        .CpuRst     (CpuRst),
        .MdStartE   (MdStartE),
        .DCacheMiss (DCacheMiss),
        .mdStall    (md_stall),
        .MdDoneE    (MdDoneE)
    );

    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] rs, input logic used);
        if (used && RegWriteM != '0 && RdM != '0 && RdM == rs) return FWD_M;
        if (used && RegWriteW != '0 && RdW != '0 && RdW == rs) return FWD_W;
        return FWD_NONE;
    endfunction

    assign load_use  = MemToRegE && RdE != '0 && (RdE == Rs1D || RdE == Rs2D);
    assign Forward1E = CpuRst ? FWD_NONE : fwd_sel(Rs1E, RegReadE[1]);
    assign Forward2E = CpuRst ? FWD_NONE : fwd_sel(Rs2E, RegReadE[0]);

    always_comb begin
        {StallF, StallD, StallE, StallM, StallW} = '0;
        {FlushF, FlushD, FlushE, FlushM, FlushW} = '0;
        if (CpuRst) begin
            {FlushF, FlushD, FlushE, FlushM, FlushW} = '1;
        end else if (DCacheMiss) begin
            {StallF, StallD, StallE, StallM} = '1;
            FlushW = 1'b1;
        end else if (md_stall) begin
            {StallF, StallD, StallE} = '1;
            FlushM = 1'b1;
        end else if (load_use) begin
            {StallF, StallD} = '1;
            FlushE = 1'b1;
        end else if (BranchE || JalrE) begin
            {FlushD, FlushE} = '1;
        end else if (JalD) begin
            FlushD = 1'b1;
        end else if (ICacheMiss) begin
            StallF = 1'b1;
            FlushD = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
    always_ff @(posedge clk) begin
        if (CpuRst) stall_cnt <= '0;
        else if (StallF && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
    end
    assign StallCycles = stall_cnt;
`else
    assign StallCycles = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors with literal checks plus a per-cycle compare against a behavioural model.
module tb_hazard_ctrl;
    localparam int REG_W  = 5;
    localparam int MD_LAT = 4;
    localparam int CNT_W  = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic CpuRst, ICacheMiss, DCacheMiss, BranchE, JalrE, JalD, MdStartE, MemToRegE;
    logic [REG_W-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0] RegReadE;
    logic [2:0] RegWriteM, RegWriteW;
    logic StallF, StallD, StallE, StallM, StallW, FlushF, FlushD, FlushE, FlushM, FlushW;
    logic [1:0] Forward1E, Forward2E;
    logic MdDoneE;
    logic [CNT_W-1:0] StallCycles;
    logic [9:0] ctl;

    hazard_ctrl #(.REG_W(REG_W), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .CpuRst(CpuRst), .ICacheMiss(ICacheMiss), .DCacheMiss(DCacheMiss),
        .BranchE(BranchE), .JalrE(JalrE), .JalD(JalD), .MdStartE(MdStartE),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegReadE(RegReadE), .MemToRegE(MemToRegE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
        .FlushF(FlushF), .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
        .Forward1E(Forward1E), .Forward2E(Forward2E), .MdDoneE(MdDoneE), .StallCycles(StallCycles)
    );

    assign ctl = {StallF, StallD, StallE, StallM, StallW, FlushF, FlushD, FlushE, FlushM, FlushW};

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: age = cycles the current mul/div has already spent in E (0 when none).
    int age = 0;
    logic [CNT_W-1:0] scnt = '0;

    function automatic logic md_active();
        return age > 0 || MdStartE;
    endfunction

    function automatic logic [9:0] exp_ctl();
        if (CpuRst) return 10'b00000_11111;
        if (DCacheMiss) return 10'b11110_00001;
        if (md_active() && age + 1 < MD_LAT) return 10'b11100_00010;
        if (MemToRegE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D)) return 10'b11000_00100;
        if (BranchE || JalrE) return 10'b00000_01100;
        if (JalD) return 10'b00000_01000;
        if (ICacheMiss) return 10'b10000_01000;
        return 10'b0;
    endfunction

    function automatic logic exp_done();
        return !CpuRst && age > 0 && age + 1 >= MD_LAT;
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [REG_W-1:0] rs, input logic used);
        if (CpuRst || !used) return 2'b00;
        if (RegWriteM != 0 && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW != 0 && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [CNT_W-1:0] exp_cycles();
`ifdef HAZARD_PERF_CNT_EN
        return scnt;
`else
        return '0;
`endif
    endfunction

    always @(posedge clk) begin
        logic [9:0] e;
        e = exp_ctl();
        if (CpuRst) begin
            age  <= 0;
            scnt <= '0;
        end else begin
            if (e[9] && scnt != '1) scnt <= scnt + 1'b1;
            if (exp_done() && !DCacheMiss) age <= 0;
            else if (md_active()) age <= (age + 1 < MD_LAT - 1) ? age + 1 : MD_LAT - 1;
            else age <= 0;
        end
    end

    always @(negedge clk) begin
        chk("model_ctl", 32'(ctl), 32'(exp_ctl()));
        chk("model_fwd1", 32'(Forward1E), 32'(exp_fwd(Rs1E, RegReadE[1])));
        chk("model_fwd2", 32'(Forward2E), 32'(exp_fwd(Rs2E, RegReadE[0])));
        chk("model_done", 32'(MdDoneE), 32'(exp_done()));
        chk("model_cycles", 32'(StallCycles), 32'(exp_cycles()));
    end

    task automatic clr();
        {ICacheMiss, DCacheMiss, BranchE, JalrE, JalD, MdStartE, MemToRegE} = '0;
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        RegReadE = '0; RegWriteM = '0; RegWriteW = '0;
    endtask

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic look();
        @(negedge clk); #1;
    endtask

    initial begin
        clr();
        CpuRst = 1; DCacheMiss = 1; MdStartE = 1;
        RdM = 7; Rs1E = 7; RegWriteM = 1; RegReadE = 2'b11;
        look();
        chk("rst_ctl", 32'(ctl), 32'h01F);
        chk("rst_fwd1", 32'(Forward1E), 0);
        chk("rst_done", 32'(MdDoneE), 0);
        nxt(); clr(); CpuRst = 1;
        look();
        chk("rst_cycles", StallCycles, 0);

        nxt(); clr(); CpuRst = 0; MemToRegE = 1; RdE = 5; Rs2D = 5; Rs1D = 3;
        look();
        chk("loaduse_ctl", 32'(ctl), 32'(10'b11000_00100));
        nxt(); clr();
        look();
        chk("loaduse_after", 32'(ctl), 0);
        nxt(); MemToRegE = 1; RdE = 0;
        look();
        chk("loaduse_rd0", 32'(ctl), 0);

        nxt(); clr(); RdM = 7; RdW = 7; Rs1E = 7; Rs2E = 7; RegWriteM = 1; RegWriteW = 3; RegReadE = 2'b10;
        look();
        chk("fwd_m_prio", 32'(Forward1E), 32'(2'b10));
        chk("fwd2_unused", 32'(Forward2E), 0);
        nxt(); RdM = 0;
        look();
        chk("fwd_w", 32'(Forward1E), 32'(2'b01));

        nxt(); clr(); MdStartE = 1;
        for (int i = 0; i < 3; i++) begin
            look();
            chk("md_stall_ctl", 32'(ctl), 32'(10'b11100_00010));
            chk("md_stall_done", 32'(MdDoneE), 0);
            nxt();
        end
        look();
        chk("md_done_ctl", 32'(ctl), 0);
        chk("md_done", 32'(MdDoneE), 1);
        nxt(); MdStartE = 0;
        look();
        chk("md_idle_ctl", 32'(ctl), 0);
        chk("md_idle_done", 32'(MdDoneE), 0);

        nxt(); clr(); MdStartE = 1;
        look();
        chk("mddm_c1", 32'(ctl), 32'(10'b11100_00010));
        for (int c = 2; c <= 6; c++) begin
            nxt(); DCacheMiss = 1;
            look();
            chk("mddm_ctl", 32'(ctl), 32'(10'b11110_00001));
            chk("mddm_done", 32'(MdDoneE), (c >= 4) ? 1 : 0);
        end
        nxt(); DCacheMiss = 0;
        look();
        chk("mddm_c7_ctl", 32'(ctl), 0);
        chk("mddm_c7_done", 32'(MdDoneE), 1);
        nxt(); MdStartE = 0;
        look();
        chk("mddm_idle", 32'(MdDoneE), 0);

        nxt(); clr(); BranchE = 1; ICacheMiss = 1;
        look();
        chk("br_icm", 32'(ctl), 32'(10'b00000_01100));
        nxt(); clr(); JalD = 1;
        look();
        chk("jal", 32'(ctl), 32'(10'b00000_01000));
        nxt(); clr(); ICacheMiss = 1;
        look();
        chk("icm", 32'(ctl), 32'(10'b10000_01000));

        nxt(); clr(); MdStartE = 1;
        look();
        nxt(); CpuRst = 1;
        look();
        chk("busy_rst_ctl", 32'(ctl), 32'h01F);
        nxt(); CpuRst = 0; MdStartE = 0;
        look();
        chk("busy_rst_idle", 32'(ctl), 0);
        chk("busy_rst_done", 32'(MdDoneE), 0);
        chk("busy_rst_cycles", StallCycles, 0);

        for (int i = 0; i < 5; i++) begin
            nxt(); clr(); ICacheMiss = 1;
            look();
        end
        nxt(); clr();
        look();
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_cnt", StallCycles, 5);
`else
        chk("perf_tied", StallCycles, 0);
`endif
        nxt();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
